// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage instruction in, EX operand selects and pipeline-control strobes out.
interface fwd_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      ifid_ir;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             stall;
    logic             bubble;
    logic             flush;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output ifid_ir,
        input  fa, fb, stall, bubble, flush, stall_count
    );

    modport slave (
        input  ifid_ir,
        output fa, fb, stall, bubble, flush, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use/jump hazard control for the 5-stage pipeline.
// Shadows EX/MEM destinations and registers the EX operand-mux selects.
module fwd_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input logic              clock,
    input logic              reset,
    fwd_hazard_ctrl_if.slave bus
);
    localparam logic [5:0] ALU_OP = 6'd0;
    localparam logic [5:0] J_OP   = 6'd2;
    localparam logic [5:0] JAL_OP = 6'd3;
    localparam logic [5:0] ADDI   = 6'd8;
    localparam logic [5:0] LW     = 6'd35;
    localparam logic [5:0] SW     = 6'd43;

    typedef enum logic {RUN, LU_STALL} state_e;

    state_e           state_q, state_d;
    logic [4:0]       ex_dest_q, ex_dest_d;
    logic             ex_load_q, ex_load_d;
    logic [4:0]       mem_dest_q, mem_dest_d;
    logic [1:0]       fa_q, fa_d;
    logic [1:0]       fb_q, fb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [5:0] op;
    logic [4:0] rs, rt, rd;
    logic [4:0] id_dest;
    logic       use_rs, use_rt;
    logic       load_use;
    logic       stall;
    logic       unused_ir;

    assign op        = bus.ifid_ir[31:26];
    assign rs        = bus.ifid_ir[25:21];
    assign rt        = bus.ifid_ir[20:16];
    assign rd        = bus.ifid_ir[15:11];
    assign unused_ir = ^bus.ifid_ir[10:0];

    always_comb begin
        id_dest = 5'd0;
        if (op == ALU_OP)
            id_dest = rd;
        else if (op == LW || op == ADDI)
            id_dest = rt;
        else if (op == JAL_OP)
            id_dest = 5'd31;
    end

    assign use_rs = (op == ALU_OP) || (op == LW) ||
                    (op == SW) || (op == ADDI);
    assign use_rt = (op == ALU_OP);

    assign load_use = ex_load_q && (ex_dest_q != 5'd0) &&
                      ((use_rs && rs == ex_dest_q) ||
                       (use_rt && rt == ex_dest_q));

    // EX-stage producer wins over the older MEM-stage copy.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] r,
        input logic [4:0] exd,
        input logic [4:0] memd
    );
        if (r != 5'd0 && r == exd)
            return 2'b10;
        else if (r != 5'd0 && r == memd)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        state_d    = state_q;
        stall      = 1'b0;
        ex_dest_d  = id_dest;
        ex_load_d  = (op == LW);
        mem_dest_d = ex_dest_q;
        fa_d       = use_rs ? fwd_sel(rs, ex_dest_q, mem_dest_q) : 2'b00;
        fb_d       = use_rt ? fwd_sel(rt, ex_dest_q, mem_dest_q) : 2'b00;
        cnt_d      = cnt_q;
        unique case (state_q)
            RUN: begin
                stall = load_use;
                if (load_use)
                    state_d = LU_STALL;
            end
            LU_STALL: begin
                // ex_dest is zero here, so load_use cannot fire
                stall   = load_use;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (stall) begin
            ex_dest_d = 5'd0;
            ex_load_d = 1'b0;
            fa_d      = 2'b00;
            fb_d      = 2'b00;
            if (cnt_q != {CNT_W{1'b1}})
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            ex_dest_q  <= 5'd0;
            ex_load_q  <= 1'b0;
            mem_dest_q <= 5'd0;
            fa_q       <= 2'b00;
            fb_q       <= 2'b00;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ex_dest_q  <= ex_dest_d;
            ex_load_q  <= ex_load_d;
            mem_dest_q <= mem_dest_d;
            fa_q       <= fa_d;
            fb_q       <= fb_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.fa          = fa_q;
    assign bus.fb          = fb_q;
    assign bus.stall       = stall;
    assign bus.bubble      = stall;
    assign bus.flush       = ~stall && (op == J_OP || op == JAL_OP);
    assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl with a queue of expected EX selects.
module tb_fwd_hazard_ctrl;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] exp_q[$];

    always #5 clock = ~clock;

    fwd_hazard_ctrl_if #(.CNT_W(32)) bus();

    fwd_hazard_ctrl #(.CNT_W(32)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    function automatic logic [31:0] rtype(input int rd, input int rs, input int rt);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] itype(input int op, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 16'd0};
    endfunction

    function automatic logic [31:0] jtype(input int op);
        return {6'(op), 26'h40};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one ID word, check the same-cycle strobes, then the registered selects.
    task automatic step(input string tag, input logic [31:0] ir,
                        input logic es, input logic ef,
                        input logic [1:0] efa, input logic [1:0] efb);
        logic [3:0] e;
        bus.ifid_ir = ir;
        #1;
        chk({tag, ".stall"}, 32'(bus.stall), 32'(es));
        chk({tag, ".bubble"}, 32'(bus.bubble), 32'(es));
        chk({tag, ".flush"}, 32'(bus.flush), 32'(ef));
        exp_q.push_back({efa, efb});
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.queue: observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".fa"}, 32'(bus.fa), 32'(e[3:2]));
            chk({tag, ".fb"}, 32'(bus.fb), 32'(e[1:0]));
        end
    endtask

    task automatic nops();
        step("nop", 32'd0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("nop", 32'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    endtask

    initial begin
        bus.ifid_ir = $urandom;
        reset = 1'b1;
        @(posedge clock);
        #1 bus.ifid_ir = $urandom;
        @(posedge clock);
        #1;
        chk("rst.stall_during", 32'(bus.stall), 32'd0);
        bus.ifid_ir = 32'd0;
        reset = 1'b0;
        #1;
        chk("rst.fa", 32'(bus.fa), 32'd0);
        chk("rst.fb", 32'(bus.fb), 32'd0);
        chk("rst.stall", 32'(bus.stall), 32'd0);
        chk("rst.flush", 32'(bus.flush), 32'd0);
        chk("rst.count", bus.stall_count, 32'd0);

        step("exA1", rtype(1, 2, 3), 1'b0, 1'b0, 2'b00, 2'b00);
        step("exA2", rtype(4, 1, 5), 1'b0, 1'b0, 2'b10, 2'b00);
        nops();
        step("exB1", rtype(1, 2, 3), 1'b0, 1'b0, 2'b00, 2'b00);
        step("exB2", rtype(4, 5, 1), 1'b0, 1'b0, 2'b00, 2'b10);
        nops();

        step("mem1", rtype(1, 2, 3), 1'b0, 1'b0, 2'b00, 2'b00);
        step("mem2", 32'd0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("mem3", rtype(6, 1, 1), 1'b0, 1'b0, 2'b01, 2'b01);
        nops();
        step("pri1", rtype(1, 2, 3), 1'b0, 1'b0, 2'b00, 2'b00);
        step("pri2", rtype(1, 2, 3), 1'b0, 1'b0, 2'b00, 2'b00);
        step("pri3", rtype(6, 1, 0), 1'b0, 1'b0, 2'b10, 2'b00);
        nops();

        step("lu1", itype(35, 1, 2), 1'b0, 1'b0, 2'b00, 2'b00);
        step("lu2", rtype(3, 2, 4), 1'b1, 1'b0, 2'b00, 2'b00);
        chk("lu.count1", bus.stall_count, 32'd1);
        step("lu3", rtype(3, 2, 4), 1'b0, 1'b0, 2'b01, 2'b00);
        chk("lu.count1b", bus.stall_count, 32'd1);
        nops();

        step("ll1", itype(35, 1, 2), 1'b0, 1'b0, 2'b00, 2'b00);
        step("ll2", itype(35, 2, 3), 1'b1, 1'b0, 2'b00, 2'b00);
        step("ll3", itype(35, 2, 3), 1'b0, 1'b0, 2'b01, 2'b00);
        chk("ll.count2", bus.stall_count, 32'd2);
        nops();

        step("j", jtype(2), 1'b0, 1'b1, 2'b00, 2'b00);
        step("j.next", 32'd0, 1'b0, 1'b0, 2'b00, 2'b00);
        step("jal", jtype(3), 1'b0, 1'b1, 2'b00, 2'b00);
        step("jal.use", rtype(7, 31, 0), 1'b0, 1'b0, 2'b10, 2'b00);
        nops();

        step("r0a", rtype(0, 1, 2), 1'b0, 1'b0, 2'b00, 2'b00);
        step("r0b", rtype(3, 0, 0), 1'b0, 1'b0, 2'b00, 2'b00);
        step("r0c", itype(35, 1, 0), 1'b0, 1'b0, 2'b00, 2'b00);
        step("r0d", rtype(3, 0, 0), 1'b0, 1'b0, 2'b00, 2'b00);
        chk("r0.count", bus.stall_count, 32'd2);
        nops();

        step("rs1", itype(35, 1, 2), 1'b0, 1'b0, 2'b00, 2'b00);
        bus.ifid_ir = rtype(3, 2, 4);
        #1;
        chk("rs.stall_pre", 32'(bus.stall), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("rs.stall_post", 32'(bus.stall), 32'd0);
        chk("rs.count", bus.stall_count, 32'd0);
        chk("rs.fa", 32'(bus.fa), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
